// File: rtl/ball_pkg.sv
// ball_pkg: shared types and helpers for the ball motion core.
// Holds the FSM state type, wall bit indices and velocity saturation.
package ball_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_INTEG,
    S_BOUND,
    S_FRIC
  } state_t;

  // bit positions inside wallHit = {bottom,top,right,left}
  localparam int WALL_LEFT   = 0;
  localparam int WALL_RIGHT  = 1;
  localparam int WALL_TOP    = 2;
  localparam int WALL_BOTTOM = 3;

  function automatic int sat_vel(
    input int v,
    input int lim
  );
    if (v > lim) return lim;
    if (v < -lim) return -lim;
    return v;
  endfunction

endpackage

// File: rtl/ball_axis.sv
// ball_axis: one axis of ball motion (integrate, clamp/bounce, friction).
// Ports: clk, reset; integ/bound/fric_tick phase strobes; ld_vel/ld_pos
// loads with values; pos_px integer position, vel velocity, hit_lo/hit_hi
// registered wall pulses.
module ball_axis
  import ball_pkg::*;
#(
  parameter int POS_W         = 11,
  parameter int VEL_W         = 11,
  parameter int FRAC_BITS     = 6,
  parameter int INIT_P        = 0,
  parameter int P_MIN         = 0,
  parameter int P_MAX         = 639,
  parameter int FRICTION_STEP = 1,
  parameter int BOUNCE_EN     = 1
)(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    integ,
  input  logic                    bound,
  input  logic                    fric_tick,
  input  logic                    ld_vel,
  input  logic signed [VEL_W-1:0] ld_vel_val,
  input  logic                    ld_pos,
  input  logic        [POS_W-1:0] ld_pos_val,
  output logic        [POS_W-1:0] pos_px,
  output logic signed [VEL_W-1:0] vel,
  output logic                    hit_lo,
  output logic                    hit_hi
);

  localparam int PW = POS_W + FRAC_BITS + 1;
  localparam int ONE = 2 ** FRAC_BITS;

  localparam logic signed [PW-1:0] LO =
    PW'(P_MIN * ONE);
  localparam logic signed [PW-1:0] HI =
    PW'(P_MAX * ONE);
  localparam logic signed [PW-1:0] P0 =
    PW'(INIT_P * ONE);
  localparam logic signed [VEL_W-1:0] STEP =
    VEL_W'(FRICTION_STEP);
  localparam logic signed [VEL_W-1:0] NSTEP =
    -STEP;

  logic signed [PW-1:0]    pos_q;
  logic signed [PW-1:0]    pos_n;
  logic signed [PW-1:0]    vel_ext;
  logic signed [PW-1:0]    ld_fix;
  logic signed [PW-1:0]    pos_sh;
  logic signed [VEL_W-1:0] vel_q;
  logic signed [VEL_W-1:0] vel_n;
  logic signed [VEL_W-1:0] bounce_v;
  logic signed [VEL_W-1:0] fric_v;
  logic                    hit_lo_n;
  logic                    hit_hi_n;
  logic                    unused_sh;

  assign vel_ext = PW'(vel_q);

  assign bounce_v = (BOUNCE_EN != 0) ? -vel_q : '0;

  // magnitude <= STEP collapses to zero, so sign never flips
  always_comb begin
    fric_v = '0;
    if (vel_q > STEP)
      fric_v = vel_q - STEP;
    else if (vel_q < NSTEP)
      fric_v = vel_q + STEP;
  end

  // loaded pixel is clamped into the legal range, no wall pulse
  always_comb begin
    ld_fix = HI;
    if (int'(ld_pos_val) < P_MIN)
      ld_fix = LO;
    else if (int'(ld_pos_val) <= P_MAX)
      ld_fix = PW'(ld_pos_val) <<< FRAC_BITS;
  end

  always_comb begin
    pos_n    = pos_q;
    vel_n    = vel_q;
    hit_lo_n = 1'b0;
    hit_hi_n = 1'b0;
    if (integ)
      pos_n = pos_q + vel_ext;
    if (bound) begin
      if (pos_q < LO) begin
        pos_n    = LO;
        vel_n    = bounce_v;
        hit_lo_n = 1'b1;
      end else if (pos_q > HI) begin
        pos_n    = HI;
        vel_n    = bounce_v;
        hit_hi_n = 1'b1;
      end
    end
    if (fric_tick)
      vel_n = fric_v;
    // loads come last so they override bounce/friction
    if (ld_vel)
      vel_n = ld_vel_val;
    if (ld_pos)
      pos_n = ld_fix;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pos_q  <= P0;
      vel_q  <= '0;
      hit_lo <= 1'b0;
      hit_hi <= 1'b0;
    end else begin
      pos_q  <= pos_n;
      vel_q  <= vel_n;
      hit_lo <= hit_lo_n;
      hit_hi <= hit_hi_n;
    end
  end

  assign pos_sh    = pos_q >>> FRAC_BITS;
  assign pos_px    = pos_sh[POS_W-1:0];
  assign unused_sh = ^pos_sh[PW-1:POS_W];
  assign vel       = vel_q;

endmodule

// File: rtl/ball_motion_core.sv
// ball_motion_core: per-ball fixed-point position/velocity with a
// 3-cycle per-frame update (integrate, boundary, friction).
// Ports: clk, reset (async high), startOfFrame, velocity/position write
// enables and values; outputs topLeftPosX/Y, outVelocityX/Y,
// ballStopped, wallHit {bottom,top,right,left}, busy, frameDropped.
module ball_motion_core
  import ball_pkg::*;
#(
  parameter int POS_W           = 11,
  parameter int VEL_W           = 11,
  parameter int FRAC_BITS       = 6,
  parameter int INIT_X          = 0,
  parameter int INIT_Y          = 0,
  parameter int X_MIN           = 0,
  parameter int X_MAX           = 639,
  parameter int Y_MIN           = 0,
  parameter int Y_MAX           = 479,
  parameter int FRICTION_PERIOD = 5,
  parameter int FRICTION_STEP   = 1,
  parameter int VEL_LIMIT       = 200,
  parameter int BOUNCE_EN       = 1
)(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    startOfFrame,
  input  logic                    velocityWriteEnable,
  input  logic signed [VEL_W-1:0] inVelocityX,
  input  logic signed [VEL_W-1:0] inVelocityY,
  input  logic                    positionWriteEnable,
  input  logic        [POS_W-1:0] inPosX,
  input  logic        [POS_W-1:0] inPosY,
  output logic        [POS_W-1:0] topLeftPosX,
  output logic        [POS_W-1:0] topLeftPosY,
  output logic signed [VEL_W-1:0] outVelocityX,
  output logic signed [VEL_W-1:0] outVelocityY,
  output logic                    ballStopped,
  output logic              [3:0] wallHit,
  output logic                    busy,
  output logic                    frameDropped
);

  localparam int CW =
    (FRICTION_PERIOD > 1) ? $clog2(FRICTION_PERIOD) : 1;
  localparam logic [CW-1:0] CNT_LAST =
    CW'(FRICTION_PERIOD - 1);

  state_t state;
  state_t state_n;

  logic [CW-1:0] fcnt;
  logic          in_idle;
  logic          in_fric;
  logic          fric_tick;

  logic signed [VEL_W-1:0] sat_vx;
  logic signed [VEL_W-1:0] sat_vy;

  logic                    pv_q;
  logic signed [VEL_W-1:0] pvx_q;
  logic signed [VEL_W-1:0] pvy_q;
  logic                    pp_q;
  logic        [POS_W-1:0] ppx_q;
  logic        [POS_W-1:0] ppy_q;

  logic                    ld_vel;
  logic signed [VEL_W-1:0] ld_vx;
  logic signed [VEL_W-1:0] ld_vy;
  logic                    ld_pos;
  logic        [POS_W-1:0] ld_px;
  logic        [POS_W-1:0] ld_py;

  logic hx_lo;
  logic hx_hi;
  logic hy_lo;
  logic hy_hi;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= S_IDLE;
    else
      state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (startOfFrame) state_n = S_INTEG;
      S_INTEG: state_n = S_BOUND;
      S_BOUND: state_n = S_FRIC;
      S_FRIC:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  assign in_idle   = (state == S_IDLE);
  assign in_fric   = (state == S_FRIC);
  assign busy      = !in_idle;
  assign fric_tick = in_fric && (fcnt == CNT_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      fcnt <= '0;
    else if (in_fric)
      fcnt <= fric_tick ? '0 : fcnt + CW'(1);
  end

  assign sat_vx =
    VEL_W'(sat_vel(int'(inVelocityX), VEL_LIMIT));
  assign sat_vy =
    VEL_W'(sat_vel(int'(inVelocityY), VEL_LIMIT));

  // writes during INTEG/BOUND are parked until FRIC
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pv_q  <= 1'b0;
      pvx_q <= '0;
      pvy_q <= '0;
      pp_q  <= 1'b0;
      ppx_q <= '0;
      ppy_q <= '0;
    end else begin
      if (in_fric) begin
        pv_q <= 1'b0;
        pp_q <= 1'b0;
      end else if (busy) begin
        if (velocityWriteEnable) begin
          pv_q  <= 1'b1;
          pvx_q <= sat_vx;
          pvy_q <= sat_vy;
        end
        if (positionWriteEnable) begin
          pp_q  <= 1'b1;
          ppx_q <= inPosX;
          ppy_q <= inPosY;
        end
      end
    end
  end

  // a write in the FRIC cycle itself is newer than the parked one
  always_comb begin
    ld_vel = 1'b0;
    ld_vx  = sat_vx;
    ld_vy  = sat_vy;
    ld_pos = 1'b0;
    ld_px  = inPosX;
    ld_py  = inPosY;
    if (in_idle) begin
      ld_vel = velocityWriteEnable;
      ld_pos = positionWriteEnable;
    end else if (in_fric) begin
      ld_vel = velocityWriteEnable | pv_q;
      ld_pos = positionWriteEnable | pp_q;
      if (!velocityWriteEnable) begin
        ld_vx = pvx_q;
        ld_vy = pvy_q;
      end
      if (!positionWriteEnable) begin
        ld_px = ppx_q;
        ld_py = ppy_q;
      end
    end
  end

  ball_axis #(
    .POS_W         (POS_W),
    .VEL_W         (VEL_W),
    .FRAC_BITS     (FRAC_BITS),
    .INIT_P        (INIT_X),
    .P_MIN         (X_MIN),
    .P_MAX         (X_MAX),
    .FRICTION_STEP (FRICTION_STEP),
    .BOUNCE_EN     (BOUNCE_EN)
  ) u_x (
    .clk        (clk),
    .reset      (reset),
    .integ      (state == S_INTEG),
    .bound      (state == S_BOUND),
    .fric_tick  (fric_tick),
    .ld_vel     (ld_vel),
    .ld_vel_val (ld_vx),
    .ld_pos     (ld_pos),
    .ld_pos_val (ld_px),
    .pos_px     (topLeftPosX),
    .vel        (outVelocityX),
    .hit_lo     (hx_lo),
    .hit_hi     (hx_hi)
  );

  ball_axis #(
    .POS_W         (POS_W),
    .VEL_W         (VEL_W),
    .FRAC_BITS     (FRAC_BITS),
    .INIT_P        (INIT_Y),
    .P_MIN         (Y_MIN),
    .P_MAX         (Y_MAX),
    .FRICTION_STEP (FRICTION_STEP),
    .BOUNCE_EN     (BOUNCE_EN)
  ) u_y (
    .clk        (clk),
    .reset      (reset),
    .integ      (state == S_INTEG),
    .bound      (state == S_BOUND),
    .fric_tick  (fric_tick),
    .ld_vel     (ld_vel),
    .ld_vel_val (ld_vy),
    .ld_pos     (ld_pos),
    .ld_pos_val (ld_py),
    .pos_px     (topLeftPosY),
    .vel        (outVelocityY),
    .hit_lo     (hy_lo),
    .hit_hi     (hy_hi)
  );

  assign wallHit[WALL_LEFT]   = hx_lo;
  assign wallHit[WALL_RIGHT]  = hx_hi;
  assign wallHit[WALL_TOP]    = hy_lo;
  assign wallHit[WALL_BOTTOM] = hy_hi;

  assign ballStopped =
    (outVelocityX == '0) && (outVelocityY == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      frameDropped <= 1'b0;
    else
      frameDropped <= startOfFrame && busy;
  end

endmodule

// File: tb/tb_ball_motion_core.sv
// tb_ball_motion_core: scoreboard bench for two ball_motion_core
// configurations driven by the same stimulus.
module tb_ball_motion_core;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic startOfFrame = 1'b0;
  logic vwe = 1'b0;
  logic pwe = 1'b0;
  logic signed [10:0] ivx = '0;
  logic signed [10:0] ivy = '0;
  logic [10:0] ipx = '0;
  logic [10:0] ipy = '0;

  logic        [10:0] o_px [2];
  logic        [10:0] o_py [2];
  logic signed [10:0] o_vx [2];
  logic signed [10:0] o_vy [2];
  logic               o_stop [2];
  logic         [3:0] o_hit [2];
  logic               o_busy [2];
  logic               o_drop [2];

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  ball_motion_core #(
    .INIT_X (100),
    .INIT_Y (100)
  ) u0 (
    .clk                 (clk),
    .reset               (reset),
    .startOfFrame        (startOfFrame),
    .velocityWriteEnable (vwe),
    .inVelocityX         (ivx),
    .inVelocityY         (ivy),
    .positionWriteEnable (pwe),
    .inPosX              (ipx),
    .inPosY              (ipy),
    .topLeftPosX         (o_px[0]),
    .topLeftPosY         (o_py[0]),
    .outVelocityX        (o_vx[0]),
    .outVelocityY        (o_vy[0]),
    .ballStopped         (o_stop[0]),
    .wallHit             (o_hit[0]),
    .busy                (o_busy[0]),
    .frameDropped        (o_drop[0])
  );

  ball_motion_core #(
    .INIT_X          (100),
    .INIT_Y          (100),
    .FRICTION_PERIOD (1),
    .FRICTION_STEP   (3),
    .BOUNCE_EN       (0)
  ) u1 (
    .clk                 (clk),
    .reset               (reset),
    .startOfFrame        (startOfFrame),
    .velocityWriteEnable (vwe),
    .inVelocityX         (ivx),
    .inVelocityY         (ivy),
    .positionWriteEnable (pwe),
    .inPosX              (ipx),
    .inPosY              (ipy),
    .topLeftPosX         (o_px[1]),
    .topLeftPosY         (o_py[1]),
    .outVelocityX        (o_vx[1]),
    .outVelocityY        (o_vy[1]),
    .ballStopped         (o_stop[1]),
    .wallHit             (o_hit[1]),
    .busy                (o_busy[1]),
    .frameDropped        (o_drop[1])
  );

  // reference model: position in 1/64 px, whole-frame arithmetic
  typedef struct {
    int x; int y; int vx; int vy; int cnt;
  } mst_t;
  typedef struct {
    int step; int per; bit bounce;
  } prm_t;
  typedef struct {
    int px; int py; int vx; int vy; logic [3:0] hit;
  } exp_t;
  typedef struct {
    exp_t e0; exp_t e1; bit drop;
  } ent_t;

  mst_t m [2];
  prm_t p [2];
  ent_t q [$];

  task automatic chk(input string nm, input int act, input int req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, req);
    end
  endtask

  function automatic int satv(input int v);
    if (v > 200) return 200;
    if (v < -200) return -200;
    return v;
  endfunction

  function automatic int clampi(input int v, input int lo, input int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  function automatic int fric1(input int v, input int s);
    int mag;
    mag = (v < 0) ? -v : v;
    mag = (mag > s) ? mag - s : 0;
    return (v < 0) ? -mag : mag;
  endfunction

  task automatic axis_step(input int pos, input int v, input int lo,
                           input int hi, input bit bnc,
                           output int npos, output int nv,
                           output bit hlo, output bit hhi);
    npos = pos; nv = v;
    hlo = (pos < lo); hhi = (pos > hi);
    if (hlo || hhi) begin
      npos = hlo ? lo : hi;
      nv = bnc ? -v : 0;
    end
  endtask

  task automatic mreset();
    for (int d = 0; d < 2; d++) begin
      m[d].x = 6400; m[d].y = 6400;
      m[d].vx = 0; m[d].vy = 0; m[d].cnt = 0;
    end
  endtask

  task automatic mwrite(input bit wv, input int vx, input int vy,
                        input bit wp, input int px, input int py);
    for (int d = 0; d < 2; d++) begin
      if (wv) begin m[d].vx = satv(vx); m[d].vy = satv(vy); end
      if (wp) begin
        m[d].x = clampi(px, 0, 639) * 64;
        m[d].y = clampi(py, 0, 479) * 64;
      end
    end
  endtask

  task automatic mframe(input int d, input bit wv, input int vx,
                        input int vy, input bit wp, input int px,
                        input int py, output exp_t e);
    int nx, ny, nvx, nvy;
    bit l, r, t, b;
    axis_step(m[d].x + m[d].vx, m[d].vx, 0, 639 * 64,
              p[d].bounce, nx, nvx, l, r);
    axis_step(m[d].y + m[d].vy, m[d].vy, 0, 479 * 64,
              p[d].bounce, ny, nvy, t, b);
    if (m[d].cnt == p[d].per - 1) begin
      m[d].cnt = 0;
      nvx = fric1(nvx, p[d].step);
      nvy = fric1(nvy, p[d].step);
    end else begin
      m[d].cnt++;
    end
    if (wv) begin nvx = satv(vx); nvy = satv(vy); end
    if (wp) begin
      nx = clampi(px, 0, 639) * 64;
      ny = clampi(py, 0, 479) * 64;
    end
    m[d].x = nx; m[d].y = ny; m[d].vx = nvx; m[d].vy = nvy;
    e.px = nx / 64; e.py = ny / 64;
    e.vx = nvx; e.vy = nvy;
    e.hit = {b, t, r, l};
  endtask

  task automatic drive(input bit wv, input int vx, input int vy,
                       input bit wp, input int px, input int py);
    vwe = wv; ivx = 11'(vx); ivy = 11'(vy);
    pwe = wp; ipx = 11'(px); ipy = 11'(py);
  endtask

  task automatic check_state(input string tag);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("%s d%0d px", tag, d), int'(o_px[d]), m[d].x / 64);
      chk($sformatf("%s d%0d py", tag, d), int'(o_py[d]), m[d].y / 64);
      chk($sformatf("%s d%0d vx", tag, d), int'(o_vx[d]), m[d].vx);
      chk($sformatf("%s d%0d vy", tag, d), int'(o_vy[d]), m[d].vy);
    end
  endtask

  task automatic idle_write(input bit wv, input int vx, input int vy,
                            input bit wp, input int px, input int py);
    @(negedge clk);
    drive(wv, vx, vy, wp, px, py);
    mwrite(wv, vx, vy, wp, px, py);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0);
    check_state("idle_write");
  endtask

  // when: 0 = with startOfFrame, 1..3 = during busy cycle k
  // drop: 0 = none, 1..3 = extra startOfFrame in busy cycle k
  task automatic frame(input int when, input bit wv, input int vx,
                       input int vy, input bit wp, input int px,
                       input int py, input int drop);
    ent_t en;
    bit bw, bp;
    @(negedge clk);
    startOfFrame = 1'b1;
    if (when == 0) begin
      drive(wv, vx, vy, wp, px, py);
      mwrite(wv, vx, vy, wp, px, py);
    end
    bw = (when != 0) && wv;
    bp = (when != 0) && wp;
    mframe(0, bw, vx, vy, bp, px, py, en.e0);
    mframe(1, bw, vx, vy, bp, px, py, en.e1);
    en.drop = (drop != 0);
    q.push_back(en);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      startOfFrame = (drop == k);
      drive(0, 0, 0, 0, 0, 0);
      if (when == k) drive(wv, vx, vy, wp, px, py);
    end
    @(negedge clk);
    startOfFrame = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
  endtask

  // monitor: accumulates pulses while busy, compares when busy falls
  int bcnt [2] = '{0, 0};
  logic [3:0] hacc [2] = '{4'd0, 4'd0};
  logic dacc [2] = '{1'b0, 1'b0};

  always @(negedge clk) begin
    ent_t en;
    exp_t e;
    if (reset) begin
      for (int d = 0; d < 2; d++) begin
        bcnt[d] = 0; hacc[d] = '0; dacc[d] = 1'b0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (o_busy[d]) begin
          bcnt[d]++;
          hacc[d] = hacc[d] | o_hit[d];
          dacc[d] = dacc[d] | o_drop[d];
        end
      end
      if (!o_busy[0] && bcnt[0] != 0) begin
        if (q.size() == 0) begin
          chk("unexpected frame", 1, 0);
        end else begin
          en = q.pop_front();
          for (int d = 0; d < 2; d++) begin
            if (d == 0) e = en.e0;
            else e = en.e1;
            dacc[d] = dacc[d] | o_drop[d];
            chk($sformatf("d%0d busy_cycles", d), bcnt[d], 3);
            chk($sformatf("d%0d px", d), int'(o_px[d]), e.px);
            chk($sformatf("d%0d py", d), int'(o_py[d]), e.py);
            chk($sformatf("d%0d vx", d), int'(o_vx[d]), e.vx);
            chk($sformatf("d%0d vy", d), int'(o_vy[d]), e.vy);
            chk($sformatf("d%0d stopped", d), int'(o_stop[d]),
                int'(e.vx == 0 && e.vy == 0));
            chk($sformatf("d%0d wallHit", d), int'(hacc[d]),
                int'(e.hit));
            chk($sformatf("d%0d frameDropped", d), int'(dacc[d]),
                int'(en.drop));
          end
        end
        for (int d = 0; d < 2; d++) begin
          bcnt[d] = 0; hacc[d] = '0; dacc[d] = 1'b0;
        end
      end
    end
  end

  task automatic check_reset_values(input string tag);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("%s d%0d px", tag, d), int'(o_px[d]), 100);
      chk($sformatf("%s d%0d py", tag, d), int'(o_py[d]), 100);
      chk($sformatf("%s d%0d vx", tag, d), int'(o_vx[d]), 0);
      chk($sformatf("%s d%0d vy", tag, d), int'(o_vy[d]), 0);
      chk($sformatf("%s d%0d stopped", tag, d), int'(o_stop[d]), 1);
      chk($sformatf("%s d%0d busy", tag, d), int'(o_busy[d]), 0);
      chk($sformatf("%s d%0d wallHit", tag, d), int'(o_hit[d]), 0);
      chk($sformatf("%s d%0d dropped", tag, d), int'(o_drop[d]), 0);
    end
  endtask

  initial begin
    int when, drop, vx, vy, px, py;
    bit wv, wp;
    p[0].step = 1; p[0].per = 5; p[0].bounce = 1'b1;
    p[1].step = 3; p[1].per = 1; p[1].bounce = 1'b0;
    mreset();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_reset_values("reset");

    // basic integration and friction timing
    idle_write(1, 64, -32, 0, 0, 0);
    repeat (5) frame(0, 0, 0, 0, 0, 0, 0, 0);
    check_state("after5");

    // saturation
    idle_write(1, 300, -500, 0, 0, 0);
    frame(0, 0, 0, 0, 0, 0, 0, 0);

    // small velocity against a large step
    idle_write(1, 1, 0, 0, 0, 0);
    repeat (2) frame(0, 0, 0, 0, 0, 0, 0, 0);

    // right wall hit from X_MAX-1
    idle_write(1, 128, 0, 1, 638, 200);
    frame(0, 0, 0, 0, 0, 0, 0, 0);

    // write during BOUND, dropped frame during INTEG
    frame(2, 1, -50, 20, 0, 0, 0, 1);
    // coincident write, dropped frame during FRIC
    frame(0, 1, 10, 10, 1, 300, 300, 3);
    // position write in INTEG overrides, velocity write in FRIC
    frame(1, 0, 0, 0, 1, 5, 470, 0);
    frame(3, 1, -120, 90, 0, 0, 0, 2);

    // reset in the middle of INTEG
    @(negedge clk);
    startOfFrame = 1'b1;
    @(negedge clk);
    startOfFrame = 1'b0;
    #2 reset = 1'b1;
    #1 check_reset_values("midreset");
    @(negedge clk);
    #2 reset = 1'b0;
    mreset();
    frame(0, 1, 40, -40, 0, 0, 0, 0);
    frame(0, 0, 0, 0, 0, 0, 0, 0);

    // randomized frames
    for (int i = 0; i < 60; i++) begin
      when = $urandom_range(0, 3);
      wv = ($urandom_range(0, 1) == 1);
      wp = ($urandom_range(0, 3) == 0);
      vx = $urandom_range(0, 1000) - 500;
      vy = $urandom_range(0, 1000) - 500;
      px = $urandom_range(0, 700);
      py = $urandom_range(0, 560);
      drop = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
      if ($urandom_range(0, 4) == 0)
        idle_write(wv, vx, vy, wp, px, py);
      else
        frame(when, wv, vx, vy, wp, px, py, drop);
    end

    repeat (4) @(negedge clk);
    chk("queue empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
